// File: rtl/fixed_addsub_pipe.sv
// Two-stage signed fixed-point add/subtract with valid/ready on both sides.
// Define SATURATE_EN to clamp overflowed results; otherwise results wrap.
module fixed_addsub_pipe #(
  parameter int Width    = 32,
  parameter int Frac     = 21,
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [Width-1:0]    a_i,
  input  logic [Width-1:0]    b_i,
  input  logic                sub_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [Width-1:0]    res_o,
  output logic                ovf_o,
  output logic [CntWidth-1:0] ovf_cnt_o
);

  if (Frac < 0 || Frac >= Width) begin : g_bad_frac
    $error("fixed_addsub_pipe: Frac must lie in [0, Width-1]");
  end

  function automatic logic signed [Width:0] addsub(input logic signed [Width-1:0] a,
                                                   input logic signed [Width-1:0] b,
                                                   input logic                    sub);
    logic signed [Width:0] ax;
    logic signed [Width:0] bx;
    ax = {a[Width-1], a};
    bx = {b[Width-1], b};
    return sub ? (ax - bx) : (ax + bx);
  endfunction

  function automatic logic ovf_of(input logic signed [Width:0] s);
    return s[Width] ^ s[Width-1];
  endfunction

  function automatic logic signed [Width-1:0] fit(input logic signed [Width:0] s);
`ifdef SATURATE_EN
    if (ovf_of(s))
      return s[Width] ? {1'b1, {(Width-1){1'b0}}} : {1'b0, {(Width-1){1'b1}}};
`endif
    return s[Width-1:0];
  endfunction

  logic signed [Width-1:0] a_p1, b_p1;
  logic                    sub_p1;
  logic                    vld_p1;
  logic signed [Width:0]   sum_p1;
  logic signed [Width-1:0] res_p2;
  logic                    ovf_p2;
  logic                    vld_p2;
  logic [CntWidth-1:0]     cnt_p2;
  logic                    s2_ready;

  // A stage may load when it is empty or its contents leave this cycle.
  assign s2_ready = !vld_p2 || ready_i;
  assign ready_o  = !vld_p1 || s2_ready;

  // Stage 1: operand capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1 <= 1'b0;
    end else if (ready_o) begin
      vld_p1 <= valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (valid_i && ready_o) begin
      a_p1   <= a_i;
      b_p1   <= b_i;
      sub_p1 <= sub_i;
    end
  end

  always_comb begin
    sum_p1 = addsub(a_p1, b_p1, sub_p1);
  end

  // Stage 2: full-width sum, overflow detect, result register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p2 <= 1'b0;
      res_p2 <= '0;
      ovf_p2 <= 1'b0;
    end else if (s2_ready) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        res_p2 <= fit(sum_p1);
        ovf_p2 <= ovf_of(sum_p1);
      end
    end
  end

  // Counts overflowed results only when they actually leave; sticks at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_p2 <= '0;
    end else if (vld_p2 && ready_i && ovf_p2 && (cnt_p2 != {CntWidth{1'b1}})) begin
      cnt_p2 <= cnt_p2 + 1'b1;
    end
  end

  assign valid_o   = vld_p2;
  assign res_o     = res_p2;
  assign ovf_o     = ovf_p2;
  assign ovf_cnt_o = cnt_p2;

endmodule
